// File: rtl/usb_bit_pkg.sv
// Shared definitions for the USB bit-level receive and transmit paths:
// stuffing limit, line idle level, FSM state encoding and the NRZI rule.
package usb_bit_pkg;

   // Consecutive decoded 1s after which the transmitter inserts one 0.
   localparam int STUFF_LIMIT_DEF = 6;

   // Idle (J) line level; also the reference level at the start of a packet.
   localparam logic J_LEVEL = 1'b1;

   // Receive FSM state encoding; kept as plain constants for older tools.
   typedef logic [0:0] rx_state_t;
   localparam rx_state_t ST_IDLE = 1'b0;
   localparam rx_state_t ST_RUN  = 1'b1;

   // NRZI: no transition on the line means a 1, a transition means a 0.
   function automatic logic nrzi_decode(input logic line_level, input logic prev_level);
      return (line_level == prev_level);
   endfunction

endpackage

// File: rtl/bit_unstuffer.sv
// Tracks runs of decoded 1s and classifies each raw bit as kept, dropped
// (the stuffed 0 that follows a full run) or a stuffing violation (a 1
// where the stuffed 0 should have been).
module bit_unstuffer
   import usb_bit_pkg::*;
#(
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  logic clk,
   input  logic nRST,
   input  logic clear,      // hold the run counter at 0 (block idle)
   input  logic raw_valid,  // a raw decoded bit is present this cycle
   input  logic raw_bit,
   output logic keep,       // raw bit is data and must be passed on
   output logic viol        // raw bit is a stuffing violation
);

   localparam int CW = $clog2(STUFF_LIMIT + 1);

   logic [CW-1:0] ones_cnt;
   logic          at_limit;

   // A full run of 1s means the next bit is the stuffed bit, never data.
   always_comb begin
      at_limit = (ones_cnt == CW'(STUFF_LIMIT));
      keep     = raw_valid && !at_limit;
      viol     = raw_valid && at_limit && raw_bit;
   end

   // Run counter: counts 1s, clears on any 0 and after the stuffed slot,
   // so it saturates at the limit and never wraps.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         ones_cnt <= '0;
      end else if (clear) begin
         ones_cnt <= '0;
      end else if (raw_valid) begin
         if (at_limit || !raw_bit) begin
            ones_cnt <= '0;
         end else begin
            ones_cnt <= ones_cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/nrzi_rx_decoder.sv
// NRZI receive decoder: turns strobed line levels into decoded bits,
// removes stuffed bits and assembles bytes LSB-first.
//
// Output handshake: dec_valid, byte_valid and stuff_err are single-cycle
// pulses with no backpressure. dec_bit is meaningful only while dec_valid
// is 1; rx_byte updates exactly in the cycle byte_valid is 1 and otherwise
// holds. All pulses come one clock after the strobe that caused them.
module nrzi_rx_decoder
   import usb_bit_pkg::*;
#(
   parameter int STUFF_LIMIT = STUFF_LIMIT_DEF
) (
   input  logic       clk,
   input  logic       nRST,
   input  logic       bit_strobe,
   input  logic       line_bit,
   input  logic       pkt_active,
   output logic       dec_bit,
   output logic       dec_valid,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       stuff_err,
   output rx_state_t  state_dbg
);

   rx_state_t  state;
   logic       prev_level;
   logic [2:0] bit_cnt;
   logic [7:0] asm_reg;
   logic [7:0] next_asm;
   logic       run_ok;
   logic       raw_valid;
   logic       raw_bit;
   logic       keep;
   logic       viol;

   // A strobe counts only in RUN with the packet still active, so a strobe
   // on the cycle pkt_active falls is ignored and idle rules apply at once.
   always_comb begin
      run_ok    = (state == ST_RUN) && pkt_active;
      raw_valid = run_ok && bit_strobe;
      raw_bit   = nrzi_decode(line_bit, prev_level);
      next_asm  = {raw_bit, asm_reg[7:1]};
      state_dbg = state;
   end

   bit_unstuffer #(
      .STUFF_LIMIT (STUFF_LIMIT)
   ) u_unstuff (
      .clk       (clk),
      .nRST      (nRST),
      .clear     (!run_ok),
      .raw_valid (raw_valid),
      .raw_bit   (raw_bit),
      .keep      (keep),
      .viol      (viol)
   );

   // Two-state FSM that simply follows pkt_active one edge later.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state <= ST_IDLE;
      end else if (pkt_active) begin
         state <= ST_RUN;
      end else begin
         state <= ST_IDLE;
      end
   end

   // Previous line level: J while idle, then every strobed level,
   // including the levels of dropped stuffed bits.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         prev_level <= J_LEVEL;
      end else if (!run_ok) begin
         prev_level <= J_LEVEL;
      end else if (raw_valid) begin
         prev_level <= line_bit;
      end
   end

   // Output pulses, byte assembly and error handling.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         dec_bit    <= 1'b0;
         dec_valid  <= 1'b0;
         byte_valid <= 1'b0;
         stuff_err  <= 1'b0;
         rx_byte    <= 8'h00;
         asm_reg    <= 8'h00;
         bit_cnt    <= 3'd0;
      end else begin
         dec_valid  <= 1'b0;
         byte_valid <= 1'b0;
         stuff_err  <= 1'b0;
         if (!run_ok) begin
            // Partial byte is discarded; rx_byte keeps the last full byte.
            bit_cnt <= 3'd0;
            asm_reg <= 8'h00;
         end else if (keep) begin
            dec_bit   <= raw_bit;
            dec_valid <= 1'b1;
            asm_reg   <= next_asm;
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_byte    <= next_asm;
               byte_valid <= 1'b1;
            end
         end else if (viol) begin
            stuff_err <= 1'b1;
            bit_cnt   <= 3'd0;
            asm_reg   <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_nrzi_rx_decoder.sv
// Directed bench for nrzi_rx_decoder: hand-computed line patterns, a
// negedge monitor logging every output pulse with its cycle stamp, and
// per-scenario tasks comparing the logs against expected values.
module tb_nrzi_rx_decoder;
   import usb_bit_pkg::*;

   logic       clk = 1'b0;
   logic       nRST = 1'b0;
   logic       bit_strobe = 1'b0;
   logic       line_bit = 1'b1;
   logic       pkt_active = 1'b0;
   logic       dec_bit;
   logic       dec_valid;
   logic [7:0] rx_byte;
   logic       byte_valid;
   logic       stuff_err;
   rx_state_t  state_dbg;

   nrzi_rx_decoder #(.STUFF_LIMIT(6)) dut (
      .clk        (clk),
      .nRST       (nRST),
      .bit_strobe (bit_strobe),
      .line_bit   (line_bit),
      .pkt_active (pkt_active),
      .dec_bit    (dec_bit),
      .dec_valid  (dec_valid),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .stuff_err  (stuff_err),
      .state_dbg  (state_dbg)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int vec_cnt = 0;
   int err_cnt = 0;

   // Stimulus and expectations
   logic [0:0] line_q[$];
   logic [0:0] exp_q[$];
   logic [7:0] exp_byte_q[$];

   // Monitor logs
   logic [0:0] dec_q[$];
   int         dec_t[$];
   logic [7:0] byte_q[$];
   int         byte_t[$];
   int         serr_t[$];
   logic [7:0] serr_byte_q[$];
   int         strb_t[$];

   always @(negedge clk) begin
      if (dec_valid) begin
         dec_q.push_back(dec_bit);
         dec_t.push_back(cyc);
      end
      if (byte_valid) begin
         byte_q.push_back(rx_byte);
         byte_t.push_back(cyc);
      end
      if (stuff_err) begin
         serr_t.push_back(cyc);
         serr_byte_q.push_back(rx_byte);
      end
   end

   // Driver tasks
   task automatic flush();
      dec_q.delete(); dec_t.delete(); byte_q.delete(); byte_t.delete();
      serr_t.delete(); serr_byte_q.delete(); strb_t.delete();
   endtask

   task automatic send_bits(input int gap);
      for (int i = 0; i < line_q.size(); i++) begin
         @(negedge clk);
         bit_strobe = 1'b1;
         line_bit   = line_q[i];
         strb_t.push_back(cyc + 1);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            bit_strobe = 1'b0;
         end
      end
      @(negedge clk);
      bit_strobe = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic start_packet();
      @(negedge clk);
      pkt_active = 1'b1;
      @(negedge clk);
   endtask

   task automatic end_packet();
      @(negedge clk);
      pkt_active = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Scenario tasks
   task automatic test_reset();
      repeat (2) @(negedge clk);
      vec_cnt++; if (dec_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_dec_valid: got %b want 0", dec_valid); end
      vec_cnt++; if (dec_bit !== 1'b0) begin err_cnt++; $display("FAIL reset_dec_bit: got %b want 0", dec_bit); end
      vec_cnt++; if (byte_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_byte_valid: got %b want 0", byte_valid); end
      vec_cnt++; if (stuff_err !== 1'b0) begin err_cnt++; $display("FAIL reset_stuff_err: got %b want 0", stuff_err); end
      vec_cnt++; if (rx_byte !== 8'h00) begin err_cnt++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
      vec_cnt++; if (state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL reset_state: got %b want %b", state_dbg, ST_IDLE); end
      nRST = 1'b1;
      flush();
      // Strobes while idle must be ignored.
      line_q = '{1'b0, 1'b1, 1'b0};
      send_bits(0);
      vec_cnt++; if (dec_q.size() != 0) begin err_cnt++; $display("FAIL idle_dec_count: got %0d want 0", dec_q.size()); end
      vec_cnt++; if (state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL idle_state: got %b want %b", state_dbg, ST_IDLE); end
   endtask

   task automatic test_basic();
      flush();
      start_packet();
      vec_cnt++; if (state_dbg !== ST_RUN) begin err_cnt++; $display("FAIL basic_state: got %b want %b", state_dbg, ST_RUN); end
      line_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_q  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      send_bits(2);
      vec_cnt++;
      if (dec_q.size() != exp_q.size()) begin
         err_cnt++; $display("FAIL basic_dec_count: got %0d want %0d", dec_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            vec_cnt++; if (dec_q[k] !== exp_q[k]) begin err_cnt++; $display("FAIL basic_dec_bit[%0d]: got %b want %b", k, dec_q[k], exp_q[k]); end
            vec_cnt++; if (dec_t[k] != strb_t[k]) begin err_cnt++; $display("FAIL basic_latency[%0d]: got cycle %0d want %0d", k, dec_t[k], strb_t[k]); end
         end
      end
      vec_cnt++;
      if (byte_q.size() != 1) begin
         err_cnt++; $display("FAIL basic_byte_count: got %0d want 1", byte_q.size());
      end else begin
         vec_cnt++; if (byte_q[0] !== 8'h15) begin err_cnt++; $display("FAIL basic_rx_byte: got %h want 15", byte_q[0]); end
         vec_cnt++; if (dec_t.size() == 8 && byte_t[0] != dec_t[7]) begin err_cnt++; $display("FAIL basic_byte_align: got cycle %0d want %0d", byte_t[0], dec_t[7]); end
      end
      end_packet();
      vec_cnt++; if (rx_byte !== 8'h15) begin err_cnt++; $display("FAIL basic_rx_hold: got %h want 15", rx_byte); end
   endtask

   task automatic test_stuffed();
      flush();
      start_packet();
      line_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_q  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      exp_byte_q = '{8'hFC, 8'hB5};
      send_bits(0);
      vec_cnt++;
      if (dec_q.size() != exp_q.size()) begin
         err_cnt++; $display("FAIL stuff_dec_count: got %0d want %0d", dec_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            vec_cnt++; if (dec_q[k] !== exp_q[k]) begin err_cnt++; $display("FAIL stuff_dec_bit[%0d]: got %b want %b", k, dec_q[k], exp_q[k]); end
         end
         vec_cnt++; if (dec_t[8] != strb_t[9]) begin err_cnt++; $display("FAIL stuff_drop_slot: got cycle %0d want %0d", dec_t[8], strb_t[9]); end
      end
      vec_cnt++;
      if (byte_q.size() != 2) begin
         err_cnt++; $display("FAIL stuff_byte_count: got %0d want 2", byte_q.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            vec_cnt++; if (byte_q[k] !== exp_byte_q[k]) begin err_cnt++; $display("FAIL stuff_rx_byte[%0d]: got %h want %h", k, byte_q[k], exp_byte_q[k]); end
         end
      end
      vec_cnt++; if (serr_t.size() != 0) begin err_cnt++; $display("FAIL stuff_no_err: got %0d pulses want 0", serr_t.size()); end
      end_packet();
   endtask

   task automatic test_stuff_err();
      flush();
      start_packet();
      line_q = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      exp_q  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_byte_q = '{8'hF3, 8'h15};
      send_bits(0);
      vec_cnt++;
      if (dec_q.size() != exp_q.size()) begin
         err_cnt++; $display("FAIL serr_dec_count: got %0d want %0d", dec_q.size(), exp_q.size());
      end else begin
         for (int k = 0; k < exp_q.size(); k++) begin
            vec_cnt++; if (dec_q[k] !== exp_q[k]) begin err_cnt++; $display("FAIL serr_dec_bit[%0d]: got %b want %b", k, dec_q[k], exp_q[k]); end
         end
      end
      vec_cnt++;
      if (serr_t.size() != 1) begin
         err_cnt++; $display("FAIL serr_pulse_count: got %0d want 1", serr_t.size());
      end else begin
         vec_cnt++; if (serr_t[0] != strb_t[10]) begin err_cnt++; $display("FAIL serr_timing: got cycle %0d want %0d", serr_t[0], strb_t[10]); end
         vec_cnt++; if (serr_byte_q[0] !== 8'hF3) begin err_cnt++; $display("FAIL serr_rx_hold: got %h want f3", serr_byte_q[0]); end
      end
      // The byte after the error must be built from fresh bits only.
      vec_cnt++;
      if (byte_q.size() != 2) begin
         err_cnt++; $display("FAIL serr_byte_count: got %0d want 2", byte_q.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            vec_cnt++; if (byte_q[k] !== exp_byte_q[k]) begin err_cnt++; $display("FAIL serr_rx_byte[%0d]: got %h want %h", k, byte_q[k], exp_byte_q[k]); end
         end
      end
      end_packet();
   endtask

   task automatic test_abort();
      flush();
      start_packet();
      line_q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      send_bits(0);
      // Strobe on the very cycle the packet ends must be ignored.
      @(negedge clk);
      pkt_active = 1'b0;
      bit_strobe = 1'b1;
      line_bit   = 1'b0;
      @(negedge clk);
      bit_strobe = 1'b0;
      repeat (2) @(negedge clk);
      vec_cnt++; if (dec_q.size() != 5) begin err_cnt++; $display("FAIL abort_dec_count: got %0d want 5", dec_q.size()); end
      vec_cnt++; if (byte_q.size() != 0) begin err_cnt++; $display("FAIL abort_no_byte: got %0d want 0", byte_q.size()); end
      vec_cnt++; if (state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL abort_state: got %b want %b", state_dbg, ST_IDLE); end
      flush();
      start_packet();
      line_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      send_bits(1);
      vec_cnt++; if (dec_q.size() != 8) begin err_cnt++; $display("FAIL abort_next_count: got %0d want 8", dec_q.size()); end
      vec_cnt++;
      if (byte_q.size() != 1) begin
         err_cnt++; $display("FAIL abort_next_bytes: got %0d want 1", byte_q.size());
      end else begin
         vec_cnt++; if (byte_q[0] !== 8'h15) begin err_cnt++; $display("FAIL abort_next_byte: got %h want 15", byte_q[0]); end
      end
      end_packet();
   endtask

   task automatic test_back_to_back();
      flush();
      start_packet();
      line_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0,
                 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      exp_byte_q = '{8'h15, 8'h8B};
      send_bits(0);
      vec_cnt++;
      if (dec_q.size() != 16) begin
         err_cnt++; $display("FAIL b2b_dec_count: got %0d want 16", dec_q.size());
      end else begin
         vec_cnt++; if (dec_t[15] - dec_t[0] != 15) begin err_cnt++; $display("FAIL b2b_dec_span: got %0d want 15", dec_t[15] - dec_t[0]); end
      end
      vec_cnt++;
      if (byte_q.size() != 2) begin
         err_cnt++; $display("FAIL b2b_byte_count: got %0d want 2", byte_q.size());
      end else begin
         for (int k = 0; k < 2; k++) begin
            vec_cnt++; if (byte_q[k] !== exp_byte_q[k]) begin err_cnt++; $display("FAIL b2b_rx_byte[%0d]: got %h want %h", k, byte_q[k], exp_byte_q[k]); end
         end
         vec_cnt++; if (byte_t[1] - byte_t[0] != 8) begin err_cnt++; $display("FAIL b2b_byte_spacing: got %0d want 8", byte_t[1] - byte_t[0]); end
      end
      end_packet();
   endtask

   task automatic test_reset_mid();
      flush();
      start_packet();
      line_q = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < line_q.size(); i++) begin
         @(negedge clk);
         bit_strobe = 1'b1;
         line_bit   = line_q[i];
      end
      @(negedge clk);
      bit_strobe = 1'b0;
      vec_cnt++; if (dec_valid !== 1'b1) begin err_cnt++; $display("FAIL rmid_pre_valid: got %b want 1", dec_valid); end
      #1 nRST = 1'b0;
      #1;
      vec_cnt++; if (dec_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_dec_valid: got %b want 0", dec_valid); end
      vec_cnt++; if (dec_bit !== 1'b0) begin err_cnt++; $display("FAIL rmid_dec_bit: got %b want 0", dec_bit); end
      vec_cnt++; if (byte_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_byte_valid: got %b want 0", byte_valid); end
      vec_cnt++; if (stuff_err !== 1'b0) begin err_cnt++; $display("FAIL rmid_stuff_err: got %b want 0", stuff_err); end
      vec_cnt++; if (rx_byte !== 8'h00) begin err_cnt++; $display("FAIL rmid_rx_byte: got %h want 00", rx_byte); end
      vec_cnt++; if (state_dbg !== ST_IDLE) begin err_cnt++; $display("FAIL rmid_state: got %b want %b", state_dbg, ST_IDLE); end
      repeat (2) @(negedge clk);
      flush();
      nRST = 1'b1;
      repeat (4) @(negedge clk);
      vec_cnt++; if (dec_q.size() + byte_q.size() + serr_t.size() != 0) begin err_cnt++; $display("FAIL rmid_quiet: got %0d pulses want 0", dec_q.size() + byte_q.size() + serr_t.size()); end
      line_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      send_bits(0);
      vec_cnt++; if (dec_q.size() != 8) begin err_cnt++; $display("FAIL rmid_dec_count: got %0d want 8", dec_q.size()); end
      vec_cnt++;
      if (byte_q.size() != 1) begin
         err_cnt++; $display("FAIL rmid_byte_count: got %0d want 1", byte_q.size());
      end else begin
         vec_cnt++; if (byte_q[0] !== 8'h15) begin err_cnt++; $display("FAIL rmid_rx_byte_new: got %h want 15", byte_q[0]); end
      end
      end_packet();
   endtask

   // Test sequence and final report
   initial begin
      test_reset();
      test_basic();
      test_stuffed();
      test_stuff_err();
      test_abort();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/nrzi_rx_decoder.md
NRZI_RX_DECODER -- requirements
Module: nrzi_rx_decoder

Interface
REQ-001 SHALL provide parameter STUFF_LIMIT, default 6: the number of consecutive decoded 1s after which one stuffed bit follows.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide port nRST, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL provide port bit_strobe, input, 1: line_bit is sampled only in cycles where bit_strobe=1.
REQ-005 SHALL provide port line_bit, input, 1: the NRZI-encoded line level; idle/J is 1.
REQ-006 SHALL provide port pkt_active, input, 1: 1 while a packet is being received; 0 returns the block to idle.
REQ-007 SHALL provide port dec_bit, output, 1: the decoded, unstuffed data bit.
REQ-008 SHALL provide port dec_valid, output, 1: a one-cycle pulse qualifying dec_bit.
REQ-009 SHALL provide port rx_byte, output, 8: the last fully assembled byte, LSB received first.
REQ-010 SHALL provide port byte_valid, output, 1: a one-cycle pulse when rx_byte updates.
REQ-011 SHALL provide port stuff_err, output, 1: a one-cycle pulse on a bit-stuffing violation.

Function
REQ-012 The decoder SHALL hold a 2-state FSM: IDLE (pkt_active=0) and RUN (pkt_active=1). The transition occurs on the first edge where pkt_active differs from the current state.
REQ-013 In IDLE, the decoder SHALL:
- force prev_level=1, ones_cnt=0 and bit_cnt=0;
- keep dec_valid, byte_valid and stuff_err at 0;
- leave rx_byte holding its last value;
- ignore strobes.
REQ-014 In RUN, on each strobe, the raw decoded bit SHALL be 1 if line_bit==prev_level and 0 otherwise; prev_level SHALL then take line_bit on every strobe, including dropped bits.
REQ-015 The ones count SHALL behave as follows:
- ones_cnt (0..STUFF_LIMIT) increments on a raw 1 when below STUFF_LIMIT;
- it clears on a raw 0;
- it saturates and never wraps.
REQ-016 When a strobe arrives with ones_cnt==STUFF_LIMIT and raw bit=0, that bit SHALL be dropped: no dec_valid, bit_cnt unchanged, ones_cnt cleared.
REQ-017 When a strobe arrives with ones_cnt==STUFF_LIMIT and raw bit=1, the decoder SHALL:
- pulse stuff_err the next cycle;
- drop the bit;
- clear ones_cnt and bit_cnt, discarding the partial byte;
- leave rx_byte unchanged.
REQ-018 For every non-dropped bit, dec_bit/dec_valid SHALL be registered and appear exactly 1 cycle after the strobe cycle.
REQ-019 Each accepted bit SHALL shift into the assembly register LSB-first, and bit_cnt SHALL increment modulo 8.
REQ-020 On the 8th accepted bit, rx_byte SHALL load the assembled value and byte_valid SHALL pulse in the same cycle as that bit's dec_valid; bit_cnt SHALL wrap to 0.
REQ-021 A strobe in the same cycle as pkt_active falling SHALL be ignored, and IDLE rules apply at that edge.
REQ-022 Back-to-back strobes (every cycle) SHALL be supported with no lost bits.
REQ-023 A partial byte at pkt_active falling SHALL be discarded without byte_valid.

Reset
REQ-024 Asserting nRST=0 SHALL immediately force:
- state=IDLE, prev_level=1, ones_cnt=0, bit_cnt=0;
- rx_byte=8'h00, assembly register=0;
- dec_bit=0, dec_valid=0, byte_valid=0, stuff_err=0.
REQ-025 Reset asserted mid-byte or mid-stuff SHALL discard all partial state, and no pulse SHALL be emitted after reset releases until new strobes arrive in RUN.

Structure
REQ-026 STUFF_LIMIT default, the FSM state enum and the J-idle level constant SHALL live in the shared package usb_bit_pkg, also used by the nrzi encoder.
REQ-027 Unstuffing (REQ-015..017) SHALL be the sub-module bit_unstuffer. NRZI decode and byte assembly SHALL remain in nrzi_rx_decoder.

Verification
REQ-028 Basic decode: pkt_active=1, strobed line 1,0,0,1,1,0,1,0 -> dec_bit 1,0,1,0,1,0,0,0, each 1 cycle after its strobe; byte_valid with rx_byte=8'h15.
REQ-029 Stuffed bit: line 1 held for 7 strobes, then 0, then the pattern continues -> six dec 1s, no dec_valid for the 8th strobe, ones_cnt cleared, no stuff_err.
REQ-030 Stuff error: line 1 held for 8 strobes -> six dec 1s, stuff_err pulse after the 8th strobe, bit_cnt=0, rx_byte unchanged.
REQ-031 Abort: pkt_active dropped after 5 accepted bits -> no byte_valid; the next packet's first 8 bits yield a byte uncorrupted by the stale 5.
REQ-032 Throughput and reset:
- strobe every cycle for 16 bits -> two byte_valid pulses exactly 8 cycles apart;
- nRST pulsed mid-byte -> all outputs 0 and rx_byte=8'h00 immediately.
